aoi211_arc_sequencer: RTL



---
 rtl/aoi211_seq_pkg.sv | 25 ++
 rtl/aoi211_seq_cmp.sv | 54 +++++
 rtl/aoi211_arc_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/aoi211_seq_pkg.sv
// rtl/aoi211_seq_pkg.sv - shared types and helpers for the AOI211 arc sequencer
package aoi211_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FIN    = 2'd3
    } seq_state_e;

    typedef logic [3:0] vec_idx_t;

    localparam int NUM_VEC = 16;

    // Gray code keeps every step a single-input arc on the cell.
    function automatic logic [3:0] gray4(input vec_idx_t i);
        return i ^ (i >> 1);
    endfunction

    function automatic logic aoi211_golden(input logic a1, input logic a2,
                                           input logic b, input logic c);
        return !((a1 & a2) | b | c);
    endfunction

endpackage

// File: rtl/aoi211_seq_cmp.sv
// rtl/aoi211_seq_cmp.sv - ZN comparator with saturating mismatch count and first-fail capture
module aoi211_seq_cmp
    import aoi211_seq_pkg::*;
#(
    parameter int ERR_W = 4
) (
    input  logic             clk_i,
    input  logic             rn_i,
    input  logic             clr_i,
    input  logic             sample_i,
    input  logic             zn_obs_i,
    input  logic [3:0]       vec_i,
    output logic             mismatch_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             fail_vld_o,
    output logic [3:0]       fail_vec_o
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    logic [ERR_W-1:0] err_cnt_q;
    logic             fail_vld_q;
    logic [3:0]       fail_vec_q;

    assign mismatch_o = sample_i &&
        (zn_obs_i != aoi211_golden(vec_i[3], vec_i[2], vec_i[1], vec_i[0]));

    always_ff @(posedge clk_i or negedge rn_i) begin
        if (!rn_i) begin
            err_cnt_q  <= '0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= 4'b0000;
        end else if (clr_i) begin
            err_cnt_q  <= '0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= 4'b0000;
        end else if (mismatch_o) begin
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_q <= err_cnt_q + ERR_ONE;
            end
            // Only the first failing vector is kept for debug.
            if (!fail_vld_q) begin
                fail_vld_q <= 1'b1;
                fail_vec_q <= vec_i;
            end
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign fail_vld_o = fail_vld_q;
    assign fail_vec_o = fail_vec_q;

endmodule

// File: rtl/aoi211_arc_sequencer.sv
// rtl/aoi211_arc_sequencer.sv - Gray-order self-test walker for one AOI211 cell
module aoi211_arc_sequencer
    import aoi211_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk_i,
    input  logic             rn_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             zn_obs_i,
    output logic             a1_o,
    output logic             a2_o,
    output logic             b_o,
    output logic             c_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             fail_vld_o,
    output logic [3:0]       fail_vec_o
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam vec_idx_t   LAST_IDX    = vec_idx_t'(NUM_VEC - 1);

    seq_state_e state_q;
    vec_idx_t   idx_q;
    logic [3:0] settle_q;
    logic [3:0] vec_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;

    logic       start_ok;
    logic       sample_en;
    logic       mismatch;

    assign start_ok  = ((state_q == ST_IDLE) || (state_q == ST_FIN)) && start_i && !abort_i;
    assign sample_en = (state_q == ST_SAMPLE) && !abort_i;

    always_ff @(posedge clk_i or negedge rn_i) begin
        if (!rn_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= 4'd0;
            vec_q    <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    if (start_ok) begin
                        state_q  <= ST_APPLY;
                        idx_q    <= '0;
                        settle_q <= 4'd0;
                        vec_q    <= gray4('0);
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        vec_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                    end else if (settle_q == SETTLE_LAST) begin
                        state_q  <= ST_SAMPLE;
                        settle_q <= 4'd0;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        vec_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                    end else if (idx_q == LAST_IDX) begin
                        state_q <= ST_FIN;
                        vec_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // The final sample lands on this same edge, so fold it in.
                        pass_q  <= (err_cnt_o == '0) && !mismatch;
                    end else begin
                        state_q <= ST_APPLY;
                        idx_q   <= idx_q + 4'd1;
                        vec_q   <= gray4(idx_q + 4'd1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    aoi211_seq_cmp #(
        .ERR_W (ERR_W)
    ) u_cmp (
        .clk_i      (clk_i),
        .rn_i       (rn_i),
        .clr_i      (start_ok),
        .sample_i   (sample_en),
        .zn_obs_i   (zn_obs_i),
        .vec_i      (vec_q),
        .mismatch_o (mismatch),
        .err_cnt_o  (err_cnt_o),
        .fail_vld_o (fail_vld_o),
        .fail_vec_o (fail_vec_o)
    );

    assign a1_o   = vec_q[3];
    assign a2_o   = vec_q[2];
    assign b_o    = vec_q[1];
    assign c_o    = vec_q[0];
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign pass_o = pass_q;

endmodule
